// File: rtl/param_comms_pkg.sv
// rtl/param_comms_pkg.sv - shared types and field constants for the parameter comms subsystem
//
// Purpose : Streamer state encoding, len_page field positions and the default
//           parameter RAM word width, shared by the parameter comms blocks.
// Ports   : none (package).

package param_comms_pkg;

    // Default width of parameter RAM words and of the outgoing stream.
    localparam int DEF_DATA_W = 32;

    // Field positions inside the 16-bit length/page PIO word.
    localparam int LP_PAGE_MSB = 15;
    localparam int LP_PAGE_LSB = 8;
    localparam int LP_LEN_MSB  = 7;
    localparam int LP_LEN_LSB  = 0;

    // Page streamer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } stream_state_e;

endpackage

// File: rtl/param_page_streamer.sv
// rtl/param_page_streamer.sv - streams one page of parameter RAM words to the coil-driver serializer
//
// Purpose : On a rising edge of start, latches {page, length} from len_page,
//           reads `length` consecutive words from the synchronous parameter RAM
//           at {page, offset} and presents them one at a time on a valid/ready
//           stream. Status (busy, done, words_sent) goes back to the Nios.
//
// Ports   :
//   clk, reset_n      system clock, asynchronous active-low reset
//   len_page          {page, length} from the length/page PIO
//   start             control PIO level; a rising edge requests a transfer
//   abort             synchronous active-high abort level
//   ram_rd, ram_addr  one-cycle read strobe and {page, offset} address
//   ram_rdata         RAM data, valid one cycle after ram_rd
//   m_data, m_valid,
//   m_ready, m_last   output stream to the serializer
//   busy, done,
//   words_sent        status PIO fields

module param_page_streamer
    import param_comms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAGE_W = 8,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = PAGE_W + LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       len_page,
    input  logic              start,
    input  logic              abort,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W:0]    words_sent
);

    stream_state_e state_q, state_d;

    logic              start_q;
    logic              armed_q, armed_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  offset_q, offset_d;
    logic [LEN_W:0]    words_q, words_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;

    logic              start_pulse;
    logic              handshake;
    logic [LEN_W-1:0]  req_len;
    logic [PAGE_W-1:0] req_page;

    assign req_page = len_page[LP_PAGE_MSB:LP_PAGE_LSB];
    assign req_len  = len_page[LP_LEN_MSB:LP_LEN_LSB];

    // armed_q only sets once start has been seen low after reset, so a start
    // level held high through reset release cannot look like a fresh edge.
    assign start_pulse = start & ~start_q & armed_q;
    assign handshake   = m_valid_q & m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
            page_q    <= '0;
            len_q     <= '0;
            offset_q  <= '0;
            words_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            armed_q   <= armed_d;
            page_q    <= page_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
            words_q   <= words_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | ~start;
        page_d    = page_q;
        len_d     = len_q;
        offset_d  = offset_q;
        words_d   = words_q;
        done_d    = done_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        ram_rd    = 1'b0;
        ram_addr  = '0;

        // A handshake is counted even in the cycle an abort lands, so the
        // reported count always matches what the serializer actually took.
        if (handshake) begin
            words_d   = words_q + (LEN_W+1)'(1);
            offset_d  = offset_q + LEN_W'(1);
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_pulse && !abort) begin
                        page_d   = req_page;
                        len_d    = req_len;
                        offset_d = '0;
                        words_d  = '0;
                        done_d   = 1'b0;
                        state_d  = (req_len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    ram_rd   = 1'b1;
                    ram_addr = {page_q, offset_q};
                    state_d  = ST_LATCH;
                end
                ST_LATCH: begin
                    m_data_d  = ram_rdata;
                    m_valid_d = 1'b1;
                    m_last_d  = (offset_q == (len_q - LEN_W'(1)));
                    state_d   = ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        state_d = m_last_q ? ST_DONE : ST_READ;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered from the next state so busy lines up with the state register.
        busy_d = (state_d != ST_IDLE);
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_param_page_streamer.sv
// tb/tb_param_page_streamer.sv - directed self-checking bench for param_page_streamer

module tb_param_page_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] len_page;
    logic        start;
    logic        abort;
    logic        ram_rd;
    logic [15:0] ram_addr;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [8:0]  words_sent;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [15:0] rd_addrs[$];
    int          rd_cycs[$];
    logic [31:0] hs_data[$];
    logic        hs_last[$];
    int          valid_cycles = 0;
    int          done_rise_cyc = -1;
    logic        done_prev = 1'b0;

    param_page_streamer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .len_page   (len_page),
        .start      (start),
        .abort      (abort),
        .ram_rd     (ram_rd),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Synchronous RAM model: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_rd) ram_rdata <= ram_word(ram_addr);
    end

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_rd) begin
            rd_addrs.push_back(ram_addr);
            rd_cycs.push_back(cyc);
        end
        if (m_valid) valid_cycles++;
        if (m_valid && m_ready) begin
            hs_data.push_back(m_data);
            hs_last.push_back(m_last);
        end
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {63'h0, done}, 64'h1);
    endtask

    int rb, hb, vb, lc, start_cyc, n;
    logic        stable;
    logic [31:0] d0;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b1;
        abort    = 1'b0;
        m_ready  = 1'b1;
        len_page = 16'h0304;
        tick(3);
        check("rst_busy",  {63'h0, busy},    64'h0);
        check("rst_done",  {63'h0, done},    64'h0);
        check("rst_valid", {63'h0, m_valid}, 64'h0);
        check("rst_last",  {63'h0, m_last},  64'h0);
        check("rst_rd",    {63'h0, ram_rd},  64'h0);
        check("rst_addr",  {48'h0, ram_addr}, 64'h0);
        check("rst_words", {55'h0, words_sent}, 64'h0);

        // start held high across reset release must not trigger a transfer
        reset_n = 1'b1;
        tick(5);
        check("hold_start_no_rd", rd_addrs.size(), 0);
        check("hold_start_busy",  {63'h0, busy}, 64'h0);

        // 4-word transfer from page 3
        start = 1'b0;
        tick();
        rb = rd_addrs.size(); hb = hs_data.size();
        start = 1'b1;
        start_cyc = cyc;
        tick(2);
        wait_done(100, "t1");
        tick(2);
        check("t1_rd_count", rd_addrs.size() - rb, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), {48'h0, rd_addrs[rb+i]}, 64'(16'h0300 + i));
            check($sformatf("t1_data%0d", i), {32'h0, hs_data[hb+i]}, {32'h0, ram_word(16'(16'h0300 + i))});
            check($sformatf("t1_last%0d", i), {63'h0, hs_last[hb+i]}, (i == 3) ? 64'h1 : 64'h0);
        end
        check("t1_first_rd_lat", rd_cycs[rb] - start_cyc, 1);
        // DONE state is 12 cycles after the first read; the done flag shows one cycle later
        check("t1_done_timing", done_rise_cyc - rd_cycs[rb], 13);
        check("t1_words", {55'h0, words_sent}, 64'd4);
        check("t1_busy",  {63'h0, busy}, 64'h0);

        // zero-length transfer
        start = 1'b0;
        len_page = 16'h0700;
        tick();
        rb = rd_addrs.size(); hb = hs_data.size(); vb = valid_cycles;
        start = 1'b1;
        start_cyc = cyc;
        tick(2);
        wait_done(20, "t2");
        tick(2);
        check("t2_no_rd",    rd_addrs.size() - rb, 0);
        check("t2_no_valid", valid_cycles - vb, 0);
        check("t2_done_lat", done_rise_cyc - start_cyc, 2);
        check("t2_words",    {55'h0, words_sent}, 64'h0);

        // backpressure on word 0
        start = 1'b0;
        len_page = 16'h0102;
        m_ready = 1'b0;
        tick();
        rb = rd_addrs.size(); hb = hs_data.size();
        start = 1'b1;
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t3_valid_seen", {63'h0, m_valid}, 64'h1);
        d0 = m_data;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== d0) stable = 1'b0;
        end
        check("t3_stable",   {63'h0, stable}, 64'h1);
        check("t3_word0",    {32'h0, d0}, {32'h0, ram_word(16'h0100)});
        check("t3_rd_stall", rd_addrs.size() - rb, 1);
        m_ready = 1'b1;
        wait_done(50, "t3");
        tick(2);
        check("t3_rd_total", rd_addrs.size() - rb, 2);
        check("t3_word1",    {32'h0, hs_data[hb+1]}, {32'h0, ram_word(16'h0101)});
        check("t3_words",    {55'h0, words_sent}, 64'd2);

        // abort after three handshakes
        start = 1'b0;
        len_page = 16'h0208;
        tick();
        hb = hs_data.size();
        start = 1'b1;
        n = 0;
        while ((hs_data.size() - hb) < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t4_three_hs", hs_data.size() - hb, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_valid", {63'h0, m_valid}, 64'h0);
        check("t4_busy",  {63'h0, busy},    64'h0);
        check("t4_done",  {63'h0, done},    64'h0);
        check("t4_words", {55'h0, words_sent}, 64'd3);
        tick(4);
        check("t4_no_more_hs", hs_data.size() - hb, 3);
        start = 1'b0;
        len_page = 16'h0201;
        tick();
        hb = hs_data.size();
        start = 1'b1;
        tick(2);
        wait_done(50, "t4b");
        tick(2);
        check("t4b_words", {55'h0, words_sent}, 64'd1);
        check("t4b_data",  {32'h0, hs_data[hb]}, {32'h0, ram_word(16'h0200)});
        check("t4b_last",  {63'h0, hs_last[hb]}, 64'h1);

        // second start edge while busy, len_page changed mid-transfer
        start = 1'b0;
        len_page = 16'h0503;
        tick();
        rb = rd_addrs.size();
        start = 1'b1;
        tick(2);
        start = 1'b0;
        len_page = 16'hFF10;
        tick();
        start = 1'b1;
        tick();
        wait_done(50, "t5");
        tick(6);
        check("t5_rd_count", rd_addrs.size() - rb, 3);
        check("t5_addr0",    {48'h0, rd_addrs[rb]},   64'h0500);
        check("t5_addr2",    {48'h0, rd_addrs[rb+2]}, 64'h0502);
        check("t5_words",    {55'h0, words_sent}, 64'd3);
        check("t5_idle",     {63'h0, busy}, 64'h0);

        // reset mid-transfer with start held high, then a 255-word transfer
        start = 1'b0;
        len_page = 16'h0304;
        tick();
        start = 1'b1;
        tick(4);
        reset_n = 1'b0;
        #1;
        rb = rd_addrs.size();
        check("t6_rst_busy",  {63'h0, busy},    64'h0);
        check("t6_rst_valid", {63'h0, m_valid}, 64'h0);
        check("t6_rst_rd",    {63'h0, ram_rd},  64'h0);
        check("t6_rst_words", {55'h0, words_sent}, 64'h0);
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("t6_no_rd_after_rst", rd_addrs.size() - rb, 0);
        start = 1'b0;
        len_page = 16'h00FF;
        tick();
        rb = rd_addrs.size(); hb = hs_data.size();
        start = 1'b1;
        tick(2);
        wait_done(900, "t6");
        tick(2);
        lc = 0;
        for (int i = hb; i < hs_data.size(); i++) if (hs_last[i]) lc++;
        check("t6_rd_count",   rd_addrs.size() - rb, 255);
        check("t6_last_addr",  {48'h0, rd_addrs[rd_addrs.size()-1]}, 64'h00FE);
        check("t6_hs_count",   hs_data.size() - hb, 255);
        check("t6_last_data",  {32'h0, hs_data[hs_data.size()-1]}, {32'h0, ram_word(16'h00FE)});
        check("t6_last_count", lc, 1);
        check("t6_words",      {55'h0, words_sent}, 64'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
